// File: rtl/dqpsk_symbol_demapper.sv
// Integrate-and-dump DQPSK symbol demapper: per-symbol I/Q sums are sliced to a
// quadrant, differentially decoded to a Gray dibit and queued in a small FIFO.
module dqpsk_symbol_demapper #(
  parameter int DATA_W     = 35,
  parameter int SPS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     sym_align,
  output logic [1:0]               out_dibit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [15:0]              sym_count
);

  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = DATA_W + CNT_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0] dump_i_q, dump_i_d, dump_q_q, dump_q_d;
  logic signed [ACC_W-1:0] ext_i, ext_q, sum_i, sum_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dump_v_q, dump_v_d;
  logic                    ref_valid_q, ref_valid_d;
  logic [1:0]              prev_quad_q, prev_quad_d;
  logic [1:0]              quad, delta;
  logic                    dec_v_q, dec_v_d;
  logic [1:0]              dec_dibit_q, dec_dibit_d;
  logic [1:0]              fifo_mem_q [FIFO_DEPTH];
  logic [1:0]              fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             sym_count_q, sym_count_d;
  logic                    pop, full, push_ok;

  // Sign extension keeps the full-symbol sum exact without saturation.
  assign ext_i = {{CNT_W{in_i[DATA_W-1]}}, in_i};
  assign ext_q = {{CNT_W{in_q[DATA_W-1]}}, in_q};
  assign sum_i = acc_i_q + ext_i;
  assign sum_q = acc_q_q + ext_q;

  always_comb begin
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    cnt_d    = cnt_q;
    dump_i_d = dump_i_q;
    dump_q_d = dump_q_q;
    dump_v_d = 1'b0;
    if (sym_align) begin
      // Alignment wins over a pending dump: the current sample starts a new window.
      acc_i_d = in_valid ? ext_i : '0;
      acc_q_d = in_valid ? ext_q : '0;
      cnt_d   = in_valid ? CNT_W'(1) : '0;
    end else if (in_valid) begin
      if (cnt_q == CNT_W'(SPS - 1)) begin
        dump_i_d = sum_i;
        dump_q_d = sum_q;
        dump_v_d = 1'b1;
        acc_i_d  = '0;
        acc_q_d  = '0;
        cnt_d    = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Quadrant index: {Q<0, (I<0)^(Q<0)} gives 0..3 counter-clockwise from +I+Q.
  assign quad  = {dump_q_q < 0, (dump_i_q < 0) ^ (dump_q_q < 0)};
  assign delta = quad - prev_quad_q;

  always_comb begin
    ref_valid_d = ref_valid_q;
    prev_quad_d = prev_quad_q;
    dec_v_d     = 1'b0;
    dec_dibit_d = dec_dibit_q;
    if (dump_v_q) begin
      prev_quad_d = quad;
      ref_valid_d = 1'b1;
      if (ref_valid_q) begin
        dec_v_d     = 1'b1;
        dec_dibit_d = {delta[1], delta[1] ^ delta[0]};
      end
    end
  end

  assign out_valid = (occ_q != '0);
  assign out_dibit = out_valid ? fifo_mem_q[rd_ptr_q] : 2'b00;
  assign overflow  = overflow_q;
  assign sym_count = sym_count_q;
  assign pop       = out_valid && out_ready;
  assign full      = (occ_q == OCC_W'(FIFO_DEPTH));
  assign push_ok   = dec_v_q && (!full || pop);

  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q | (dec_v_q && !push_ok);
    sym_count_d = sym_count_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = dec_dibit_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      sym_count_d          = sym_count_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      cnt_q       <= '0;
      dump_i_q    <= '0;
      dump_q_q    <= '0;
      dump_v_q    <= 1'b0;
      ref_valid_q <= 1'b0;
      prev_quad_q <= 2'b00;
      dec_v_q     <= 1'b0;
      dec_dibit_q <= 2'b00;
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      sym_count_q <= '0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      cnt_q       <= cnt_d;
      dump_i_q    <= dump_i_d;
      dump_q_q    <= dump_q_d;
      dump_v_q    <= dump_v_d;
      ref_valid_q <= ref_valid_d;
      prev_quad_q <= prev_quad_d;
      dec_v_q     <= dec_v_d;
      dec_dibit_q <= dec_dibit_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      sym_count_q <= sym_count_d;
    end
  end

endmodule

// File: tb/tb_dqpsk_symbol_demapper.sv
// Bench for dqpsk_symbol_demapper: directed scenarios plus random traffic, all
// checked every cycle against a sum/queue based reference model.
module tb_dqpsk_symbol_demapper;
  localparam int DATA_W = 35;
  localparam int SPS    = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic sym_align = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DATA_W-1:0] in_i = '0;
  logic signed [DATA_W-1:0] in_q = '0;
  logic [1:0]  out_dibit;
  logic        out_valid;
  logic        overflow;
  logic [15:0] sym_count;

  dqpsk_symbol_demapper #(.DATA_W(DATA_W), .SPS(SPS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .sym_align(sym_align), .out_dibit(out_dibit), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct { longint at; bit [1:0] d; } sched_t;
  longint   m_si, m_sq, m_dump_i, ec;
  int       m_n, m_prev, m_quad, m_cnt, m_pre;
  bit       m_ref, m_ovf, m_dump_now, m_pop, m_push;
  bit [1:0] m_pd;
  bit [1:0] m_fifo[$];
  sched_t   m_sched[$];
  sched_t   m_e;
  int       gray[4] = '{0, 1, 3, 2};

  logic [1:0] pop_log[$];
  longint     dump_log[$];

  initial begin
    ec = 0;
    forever begin
      @(posedge clk);
      ec++;
      m_dump_now = 0;
      if (!rstn) begin
        m_si = 0; m_sq = 0; m_n = 0; m_ref = 0; m_prev = 0;
        m_ovf = 0; m_cnt = 0;
        m_fifo.delete();
        m_sched.delete();
      end else begin
        m_pre  = m_fifo.size();
        m_pop  = (m_pre > 0) && out_ready;
        m_push = 0;
        if (m_sched.size() > 0 && m_sched[0].at == ec) begin
          m_push = 1;
          m_pd   = m_sched[0].d;
          void'(m_sched.pop_front());
        end
        if (m_pop) void'(m_fifo.pop_front());
        if (m_push) begin
          if (m_pre < DEPTH || m_pop) begin
            m_fifo.push_back(m_pd);
            m_cnt = (m_cnt + 1) % 65536;
          end else m_ovf = 1;
        end
        if (sym_align) begin
          m_si = in_valid ? longint'(in_i) : 0;
          m_sq = in_valid ? longint'(in_q) : 0;
          m_n  = in_valid ? 1 : 0;
        end else if (in_valid) begin
          m_si += longint'(in_i);
          m_sq += longint'(in_q);
          m_n++;
          if (m_n == SPS) begin
            m_dump_now = 1;
            m_dump_i   = m_si;
            if (m_si >= 0 && m_sq >= 0)  m_quad = 0;
            else if (m_si < 0 && m_sq >= 0) m_quad = 1;
            else if (m_si < 0)           m_quad = 2;
            else                         m_quad = 3;
            if (m_ref) begin
              m_e.at = ec + 2;
              m_e.d  = 2'(gray[(m_quad - m_prev + 4) % 4]);
              m_sched.push_back(m_e);
            end
            m_prev = m_quad;
            m_ref  = 1;
            m_si = 0; m_sq = 0; m_n = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("out_valid", out_valid, longint'(m_fifo.size() != 0));
      check("overflow", overflow, longint'(m_ovf));
      check("sym_count", sym_count, m_cnt);
      if (m_fifo.size() != 0) check("out_dibit", out_dibit, m_fifo[0]);
      check("dump_v", dut.dump_v_q, longint'(m_dump_now));
      if (m_dump_now && dut.dump_v_q) check("dump_i", longint'(dut.dump_i_q), m_dump_i);
      if (dut.dump_v_q) dump_log.push_back(longint'(dut.dump_i_q));
      if (rstn && out_valid && out_ready) pop_log.push_back(out_dibit);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input int quad);
    for (int j = 0; j < SPS; j++) begin
      in_valid = 1'b1;
      in_i = (quad == 1 || quad == 2) ? -DATA_W'(1000) : DATA_W'(1000);
      in_q = (quad >= 2) ? -DATA_W'(1000) : DATA_W'(1000);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_pops(input string name, input int exp[], input int n);
    check({name, "_count"}, pop_log.size(), n);
    for (int i = 0; i < n; i++)
      check(name, (i < pop_log.size()) ? longint'(pop_log[i]) : -1, exp[i]);
  endtask

  int exp_a[] = '{1, 1, 3};
  int exp_d[] = '{1, 3, 2, 0, 3};
  int vals_b[] = '{5, -3, 7, -9};
  longint v;

  initial begin
    // Reset
    rstn = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_out_dibit", out_dibit, 0);
    rstn = 1'b1;

    // Four constant symbols: first is reference only
    pop_log.delete();
    send_sym(0); send_sym(1); send_sym(2); send_sym(0);
    repeat (5) tick();
    check_pops("seq_a", exp_a, 3);
    check("seq_a_sym_count", sym_count, 3);

    // Gapped input summing to zero, then the most negative full-scale symbol
    dump_log.delete();
    for (int j = 0; j < 2 * SPS; j++) begin
      in_valid = (j % 2 == 0);
      in_i = DATA_W'(vals_b[j / 2]);
      in_q = DATA_W'(100);
      tick();
    end
    for (int j = 0; j < SPS; j++) begin
      in_valid = 1'b1;
      in_i = DATA_W'(-(longint'(1) << 34));
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("dump_log_b_count", dump_log.size(), 2);
    check("dump_zero", (dump_log.size() > 0) ? dump_log[0] : 1, 0);
    check("dump_min", (dump_log.size() > 1) ? dump_log[1] : 0, -(longint'(1) << 36));

    // sym_align on the third sample restarts the window
    dump_log.delete();
    for (int j = 0; j < 5; j++) begin
      in_valid  = 1'b1;
      sym_align = (j == 2);
      in_i = (j < 2) ? -DATA_W'(5000) : DATA_W'(1000);
      in_q = in_i;
      tick();
    end
    sym_align = 1'b0;
    in_i = DATA_W'(1000); in_q = DATA_W'(1000);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("align_count", dump_log.size(), 1);
    check("align_sum", (dump_log.size() > 0) ? dump_log[0] : 0, 4000);

    // Overflow with a stalled consumer, then push+pop while full, then drain
    rstn = 1'b0; repeat (2) tick(); rstn = 1'b1;
    out_ready = 1'b0;
    send_sym(0); send_sym(1); send_sym(3); send_sym(2); send_sym(2); send_sym(1);
    repeat (4) tick();
    check("ovf_set", overflow, 1);
    check("ovf_sym_count", sym_count, 4);
    pop_log.delete();
    send_sym(3);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pushpop_sym_count", sym_count, 5);
    check("full_pushpop_ovf", overflow, 1);
    out_ready = 1'b1;
    repeat (8) tick();
    check_pops("drain", exp_d, 5);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rstn      = ($urandom_range(0, 999) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      sym_align = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 9) < 5);
      if ($urandom_range(0, 1) == 1) begin
        v = longint'($urandom_range(0, 4000)) - 2000;
        in_i = DATA_W'(v);
        v = longint'($urandom_range(0, 4000)) - 2000;
        in_q = DATA_W'(v);
      end else begin
        in_i = DATA_W'({$urandom(), $urandom()});
        in_q = DATA_W'({$urandom(), $urandom()});
      end
      tick();
    end
    in_valid = 1'b0; sym_align = 1'b0; rstn = 1'b1; out_ready = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dqpsk_symbol_demapper.md
Name: dqpsk_symbol_demapper

Overview:
Downstream of the Costas carrier-recovery stage. Consumes the recovered baseband I/Q sample streams (35-bit signed FIR outputs) and integrates them over each symbol period (integrate-and-dump). It slices each symbol into a quadrant, differentially decodes consecutive quadrants into Gray-coded dibits, and buffers the dibits in a small output FIFO with a valid/ready handshake toward the bit-sink and BER logic.

Parameters:
DATA_W, 35, width of in_i/in_q (signed two's complement)
SPS, 16, samples per symbol; power of two, 2..256
FIFO_DEPTH, 4, output dibit FIFO depth; power of two, >=2

Ports:
clk  in  1  system clock (DDS clock domain)
rstn  in  1  synchronous active-low reset
in_valid  in  1  qualifies in_i/in_q for one cycle
in_i  in  DATA_W  signed recovered I sample
in_q  in  DATA_W  signed recovered Q sample
sym_align  in  1  pulse: restart symbol integration window
out_dibit  out  2  decoded dibit {b1,b0}
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_dibit when out_valid&&out_ready
overflow  out  1  sticky: a symbol was dropped because the FIFO was full
sym_count  out  16  number of symbols written to the FIFO, wraps at 2^16

Behaviour:
- Clock and reset: reset rstn, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: acc_i, acc_q = 0; sample counter = 0; ref_valid = 0; prev_quad = 0; FIFO empty; out_valid = 0; out_dibit = 0; overflow = 0; sym_count = 0.
- Accumulators:
  - ACC_W = DATA_W + log2(SPS), signed.
  - Inputs are sign-extended before adding. No saturation is needed because the width is exact.
- Integrate:
  - Each cycle with in_valid=1: counter increments and acc += sample.
  - When counter == SPS-1, the cycle is a dump. The sums acc+sample are registered into dump_i/dump_q, dump_v pulses for one cycle, and acc and counter return to 0. The counter wraps SPS-1 -> 0.
  - Cycles with in_valid=0 leave acc and counter unchanged.
- sym_align:
  - When asserted, acc and counter are cleared that cycle.
  - If in_valid is also high, that sample is loaded as sample 0: acc = sample, counter = 1. No dump occurs, even if counter was SPS-1.
  - ref_valid and prev_quad are unaffected.
- Quadrant slicing (zero counts as non-negative):
  - I>=0, Q>=0 -> quad 0
  - I<0, Q>=0 -> quad 1
  - I<0, Q<0 -> quad 2
  - I>=0, Q<0 -> quad 3
- Differential decode, on the cycle after the dump (dump_v):
  - delta = (quad - prev_quad) mod 4.
  - Gray map: 0->00, 1->01, 2->11, 3->10.
  - prev_quad is then set to quad.
  - The first symbol after reset only sets the reference: ref_valid goes to 1 and no dibit is produced.
- FIFO:
  - The decoded dibit is written on the cycle after decode.
  - Latency: the sample accepted at the dump edge k produces a FIFO entry at edge k+2, so out_valid is high from edge k+2 if the FIFO was empty.
  - out_dibit shows the FIFO head and is stable while out_valid && !out_ready.
  - A pop occurs on out_valid && out_ready. Simultaneous push and pop are allowed, including when the FIFO is full.
  - Full without a pop: the new dibit is dropped, overflow is set (cleared only by reset), and sym_count does not increment.
  - sym_count increments on each successful push.
- Reset mid-symbol: the partial accumulation is discarded, FIFO contents are lost, and the differential reference is cleared.

Test Plan:
- SPS=4; reset held for 3 cycles -> out_valid=0, overflow=0, sym_count=0, out_dibit=00; out_ready=1 throughout.
- SPS=4, out_ready=1; 4 symbols of constant (I,Q) = (+1000,+1000), (-1000,+1000), (-1000,-1000), (+1000,+1000) -> dibits 01, 01, 11 in order, with the first symbol as reference only; each dibit arrives 2 cycles after its 4th accepted sample.
- SPS=4; in_valid toggling 1/0 within a symbol, samples +5, -3, +7, -9 on I -> dump_i = 0, treated as non-negative; samples at I = -2^34 for all four -> dump_i = -2^36 with no wrap.
- SPS=4; sym_align pulsed alongside the 3rd sample of a symbol -> that sample becomes sample 0; the dump occurs 3 valid samples later; symbol decisions stay consistent.
- FIFO_DEPTH=4, out_ready=0; 6 symbols producing 5 dibits -> 4 stored, the 5th dropped, overflow=1, sym_count=4; raising out_ready drains the 4 in order with no duplicates.
- Push and pop in the same cycle while full -> occupancy stays 4, overflow unchanged, head advances by one.
